// File: rtl/key_pkg.sv
// rtl/key_pkg.sv - shared constants, keycode lookup and FSM encodings for key_report_encoder
//
// Contents: KEY_NUM/SLOT_NUM, USB HID usage codes for the ten keys,
// KC_NONE/KC_ROLLOVER, FSM state constants and the slot-table operation enum.
// Optional feature macro used by the top: KEY_ROLLOVER_EN.

package key_pkg;

    localparam int KEY_NUM  = 10;
    localparam int SLOT_NUM = 6;

    // Key index order: A, D, W, F, left, right, up, space, enter, esc
    localparam logic [7:0] KC_A     = 8'h04;
    localparam logic [7:0] KC_D     = 8'h07;
    localparam logic [7:0] KC_W     = 8'h1A;
    localparam logic [7:0] KC_F     = 8'h09;
    localparam logic [7:0] KC_LEFT  = 8'h50;
    localparam logic [7:0] KC_RIGHT = 8'h4F;
    localparam logic [7:0] KC_UP    = 8'h52;
    localparam logic [7:0] KC_SPACE = 8'h2C;
    localparam logic [7:0] KC_ENTER = 8'h28;
    localparam logic [7:0] KC_ESC   = 8'h29;

    localparam logic [7:0] KC_NONE     = 8'h00;
    localparam logic [7:0] KC_ROLLOVER = 8'h01;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_SCAN = 2'd1;
    localparam logic [1:0] ST_EMIT = 2'd2;

    typedef enum logic [1:0] {
        OP_NONE   = 2'd0,
        OP_INSERT = 2'd1,
        OP_REMOVE = 2'd2
    } slot_op_t;

    function automatic logic [7:0] key_code(input logic [3:0] idx);
        case (idx)
            4'd0:    key_code = KC_A;
            4'd1:    key_code = KC_D;
            4'd2:    key_code = KC_W;
            4'd3:    key_code = KC_F;
            4'd4:    key_code = KC_LEFT;
            4'd5:    key_code = KC_RIGHT;
            4'd6:    key_code = KC_UP;
            4'd7:    key_code = KC_SPACE;
            4'd8:    key_code = KC_ENTER;
            4'd9:    key_code = KC_ESC;
            default: key_code = KC_NONE;
        endcase
    endfunction

endpackage

// File: rtl/key_slot_table.sv
// rtl/key_slot_table.sv - press-ordered keycode slot table with insert and remove-with-shift
//
// Ports:
//   clk, rst_n   rising-edge clock, asynchronous active-low reset
//   op           OP_NONE / OP_INSERT / OP_REMOVE, one operation per cycle
//   code         keycode to insert or remove
//   slots        slot contents, slot 0 (bits 7:0) is the oldest entry
//   full         all SLOT_NUM slots occupied

module key_slot_table
    import key_pkg::*;
(
    input  logic                     clk,
    input  logic                     rst_n,
    input  slot_op_t                 op,
    input  logic [7:0]               code,
    output logic [SLOT_NUM-1:0][7:0] slots,
    output logic                     full
);

    logic [2:0]               cnt;
    logic [2:0]               cnt_n;
    logic [SLOT_NUM-1:0][7:0] slots_n;
    logic [SLOT_NUM-1:0][7:0] slots_down;
    logic                     shifting;
    logic                     found;

    assign full = (cnt == 3'(SLOT_NUM));

    // Element i of slots_down holds slots[i+1]; the top slot refills with KC_NONE.
    assign slots_down = {KC_NONE, slots[SLOT_NUM-1:1]};

    always_comb begin
        slots_n  = slots;
        cnt_n    = cnt;
        shifting = 1'b0;
        found    = 1'b0;
        case (op)
            OP_INSERT: begin
                if (!full) begin
                    for (int i = 0; i < SLOT_NUM; i++) begin
                        if (3'(i) == cnt) begin
                            slots_n[i] = code;
                        end
                    end
                    cnt_n = cnt + 3'd1;
                end
            end
            OP_REMOVE: begin
                // Every slot from the match upward takes its upper neighbour.
                for (int i = 0; i < SLOT_NUM; i++) begin
                    if ((3'(i) < cnt) && (slots[i] == code)) begin
                        shifting = 1'b1;
                        found    = 1'b1;
                    end
                    if (shifting) begin
                        slots_n[i] = slots_down[i];
                    end
                end
                if (found) begin
                    cnt_n = cnt - 3'd1;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            slots <= '0;
            cnt   <= 3'd0;
        end else begin
            slots <= slots_n;
            cnt   <= cnt_n;
        end
    end

endmodule

// File: rtl/key_report_encoder.sv
// rtl/key_report_encoder.sv - ten key flags to six-slot HID boot-keyboard report, emitted on change
//
// Ports:
//   clk           rising-edge system clock
//   rst_n         asynchronous active-low reset
//   key           key-held flags (A, D, W, F, left, right, up, space, enter, esc)
//   keycode       report slots, slot 0 (bits 7:0) is the oldest press, 0x00 empty
//   report_valid  report presented on keycode
//   report_ready  consumer accepts the report
// Optional feature: define KEY_ROLLOVER_EN to report ErrorRollOver while
// more than SLOT_NUM keys are held.

module key_report_encoder
    import key_pkg::*;
(
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [KEY_NUM-1:0]       key,
    output logic [SLOT_NUM-1:0][7:0] keycode,
    output logic                     report_valid,
    input  logic                     report_ready
);

    logic [KEY_NUM-1:0]       key_q;
    logic [KEY_NUM-1:0]       key_snap;
    logic [KEY_NUM-1:0]       key_held;
    logic [1:0]               state;
    logic [3:0]               idx;
    logic                     dirty;
    logic                     scan_start;
    logic                     scan_last;
    slot_op_t                 op;
    logic [7:0]               op_code;
    logic [SLOT_NUM-1:0][7:0] slots;
    logic                     full;
    logic                     ovf_change;
    logic                     show_rollover;

    assign report_valid = (state == ST_EMIT);
    assign scan_start   = (state == ST_IDLE) && (key_q != key_snap);
    // idx steps 0..KEY_NUM-1 issuing table ops, then one extra step at
    // idx == KEY_NUM lets the last op land before keycode is captured.
    assign scan_last    = (idx == 4'(KEY_NUM));
    assign op_code      = key_code(idx);

`ifdef KEY_ROLLOVER_EN
    logic ovf_q;
    logic ovf_new;

    assign ovf_new       = ($countones(key_q) > SLOT_NUM);
    assign ovf_change    = (ovf_new != ovf_q);
    assign show_rollover = ovf_q;

    // Overflow follows key_snap, so it is re-evaluated whenever a scan starts.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ovf_q <= 1'b0;
        end else if (scan_start) begin
            ovf_q <= ovf_new;
        end
    end
`else
    assign ovf_change    = 1'b0;
    assign show_rollover = 1'b0;
`endif

    always_comb begin
        op = OP_NONE;
        if ((state == ST_SCAN) && !scan_last) begin
            if (key_held[idx] && !key_snap[idx]) begin
                op = OP_REMOVE;
            end else if (!key_held[idx] && key_snap[idx] && !full) begin
                op = OP_INSERT;
            end
        end
    end

    key_slot_table u_slot_table (
        .clk   (clk),
        .rst_n (rst_n),
        .op    (op),
        .code  (op_code),
        .slots (slots),
        .full  (full)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            key_q    <= '0;
            key_snap <= '0;
            key_held <= '0;
            state    <= ST_IDLE;
            idx      <= 4'd0;
            dirty    <= 1'b0;
            keycode  <= '0;
        end else begin
            key_q <= key;
            case (state)
                ST_IDLE: begin
                    if (scan_start) begin
                        key_snap <= key_q;
                        dirty    <= ovf_change;
                        idx      <= 4'd0;
                        state    <= ST_SCAN;
                    end
                end
                ST_SCAN: begin
                    if (scan_last) begin
                        if (dirty) begin
                            keycode <= show_rollover ? {SLOT_NUM{KC_ROLLOVER}} : slots;
                            state   <= ST_EMIT;
                        end else begin
                            state <= ST_IDLE;
                        end
                    end else begin
                        idx <= idx + 4'd1;
                        if (op == OP_REMOVE) begin
                            key_held[idx] <= 1'b0;
                            dirty         <= 1'b1;
                        end else if (op == OP_INSERT) begin
                            key_held[idx] <= 1'b1;
                            dirty         <= 1'b1;
                        end
                    end
                end
                ST_EMIT: begin
                    if (report_ready) begin
                        state <= ST_IDLE;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: doc/key_report_encoder.md
# key_report_encoder

Converts ten level-sensitive key-pressed flags into a six-slot USB HID boot-keyboard keycode report. Slots are kept in press order, and a report is emitted over a valid/ready handshake only when the report content changes. The block sits on the stimulus/host-emulation side of the keyboard path and produces the same 6×8-bit keycode array that the game logic's key decoder consumes. It is used for on-board button input, replay and loopback testing.

## Interface
- KEY_NUM, 10: number of key flags; index order is A, D, W, F, left, right, up, space, enter, esc.
- SLOT_NUM, 6: keycode slots per report.
- Clk  in  1  system clock; all logic is rising-edge.
- Reset_n  in  1  reset, asynchronous assert, active-low.
- key  in  [KEY_NUM] × 1  key-held flags; asynchronous to the report logic.
- keycode  out  [SLOT_NUM] × 8  report slots; slot 0 is the oldest press; 0x00 means empty.
- report_valid  out  1  a report is presented on keycode.
- report_ready  in  1  the consumer accepts the report.

## Operation
- Codes by index: 0x04, 0x07, 0x1A, 0x09, 0x50, 0x4F, 0x52, 0x2C, 0x28, 0x29.
- key is registered once into key_q (1-cycle input stage). It is not debounced.
- Internal state:
  - key_snap: flags covered by the last scan.
  - key_held: flags that currently own a slot.
  - slot[0..5]: the slot table.
  - cnt: number of occupied slots, 0..6.
  - dirty: slot table or overflow changed during the current scan.
- FSM states: IDLE, SCAN, EMIT.
- IDLE:
  - If key_q != key_snap, latch key_snap <= key_q, clear dirty, set idx = 0, and go to SCAN.
  - Otherwise stay in IDLE.
- SCAN: one index per cycle, idx 0 to 9.
  - Release (key_held[idx]=1, key_snap[idx]=0):
    - Remove the matching slot.
    - Shift higher slots down by one and write 0x00 into slot 5.
    - cnt-1, set dirty.
  - Press (key_held[idx]=0, key_snap[idx]=1, cnt<6): write the code to slot[cnt], cnt+1, set key_held[idx], set dirty.
  - Press with cnt==6: the key is not assigned and key_held stays 0. It gets a slot on a later scan once a slot frees and any key changes.
  - At idx 9: go to EMIT if dirty, otherwise go to IDLE.
- Within one scan, releases and presses are handled strictly in index order. A slot freed at a lower index is therefore available to a press at a higher index in the same scan.
- EMIT:
  - report_valid=1.
  - keycode and report_valid are held stable until report_ready=1.
  - On the cycle where valid and ready are both high, go to IDLE.
  - key changes during EMIT are picked up by the next IDLE comparison; no change is lost.
- keycode always reflects the slot table, except during overflow (see Configuration). It is updated only on entry to EMIT, so it never glitches while valid is high.

## Timing
- Reset values: report_valid=0, keycode all 0x00, cnt=0, key_held=0, key_snap=0, state IDLE.
- Reset asserted mid-SCAN or mid-EMIT aborts the operation: no report, table cleared.
- Latency: a key change sampled into key_q at edge N produces report_valid=1 after edge N+12 (1 IDLE cycle + 10 SCAN cycles + 1 to enter EMIT).
- With report_ready tied high: one report per 13 cycles at most, with valid high for exactly one cycle.
- No report is emitted if a scan produces no net change (e.g. a press and release shorter than the sampling window, or an overflow-ignored key).

## Configuration
- KEY_ROLLOVER_EN defined:
  - While popcount(key_snap) > 6, keycode reports all six slots as 0x01 (ErrorRollOver).
  - Entering or leaving overflow sets dirty.
  - The slot table keeps tracking underneath, so the first six keys reappear when the count drops to 6 or below.
- KEY_ROLLOVER_EN undefined: keys beyond six are silently unassigned and keycode always shows the slot table.

## Structure
- Package key_pkg holds:
  - KEY_NUM and SLOT_NUM.
  - The ten keycode constants and the index-to-code lookup.
  - KC_NONE=0x00 and KC_ROLLOVER=0x01.
  - The FSM state enum.
- Sub-module key_slot_table owns slot[], cnt and the insert/remove-with-shift logic. It takes one operation per cycle: none, insert code, or remove code. It reports full and the slot contents.

## Test plan
- Press A -> one report {04,00,00,00,00,00} with valid after 12 cycles; holding A produces no further reports.
- Press A, then D 20 cycles later, then release A -> reports {04,00..}, {04,07,00..}, {07,00,00,00,00,00}.
- Hold report_ready=0 for 50 cycles while pressing W -> valid stays high and {1A,00..} is stable; the report is accepted on the first ready cycle and valid drops the next cycle.
- Press all of indices 0–6 simultaneously:
  - Macro defined -> {01,01,01,01,01,01}; releasing up (index 6) -> {04,07,1A,09,50,4F}.
  - Macro undefined -> {04,07,1A,09,50,4F}; releasing A -> {07,1A,09,50,4F,52}.
- Press and release space within 3 cycles while in EMIT -> no extra report is generated for space.
- Assert Reset_n=0 during SCAN with three keys held -> valid=0 and keycode all 0x00 immediately. After release, one report {04,07,1A,00,00,00} is emitted.
